// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: default encodings, state encoding and
// small address helpers used by the PC logic and its stage registers.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP        = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic instruction pipeline register with load / flush / hold controls.
// Priority: rst > flush > hold > load; with none asserted it keeps its value.
// A flush only turns the slot into a bubble; the address fields are left
// as they were since nothing downstream looks at them while invalid.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        valid
);

    // Stage register update in priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= 32'd0;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (hold) begin
            instr <= instr;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED control, sticky
// misalignment flag and fetch counter. imem_pc comes straight from the PC
// register so redirect/stall never reach the memory address combinationally.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR,
    parameter logic [31:0] HALT_INSTR = DEF_HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         ld, fl, hd, count_inc;

    assign pc_plus4 = pc_q + PC_STEP;   // wraps naturally at 2^32
    assign imem_pc  = pc_q;
    assign halted   = (state_q == ST_HALTED);

    // Next PC / state and stage-register controls: redirect > stall > halt > advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ld        = 1'b0;
        fl        = 1'b0;
        hd        = 1'b0;
        count_inc = 1'b0;
        if (redirect) begin
            pc_d    = word_align(redirect_pc);
            fl      = 1'b1;
            state_d = ST_RUN;
        end else if (stall) begin
            hd = 1'b1;
        end else if (state_q == ST_HALTED) begin
            fl = 1'b1;
        end else if (imem_instr == HALT_INSTR) begin
            // Halt word itself is delivered and counted; PC parks on it.
            ld        = 1'b1;
            count_inc = 1'b1;
            state_d   = ST_HALTED;
        end else begin
            ld        = 1'b1;
            count_inc = 1'b1;
            pc_d      = pc_plus4;
        end
    end

    // PC, state, sticky flag and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            misaligned  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (count_inc)
                fetch_count <= fetch_count + 32'd1;
            if (redirect && (redirect_pc[1:0] != 2'b00))
                misaligned <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .flush    (fl),
        .hold     (hd),
        .instr_in (imem_instr),
        .pc_in    (pc_q),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

endmodule
